icache_dm: RTL

//  Parametrised direct-mapped, read-only instruction cache placed between the MIPS_S

---
 rtl/icache_pkg.sv | 32 +++
 rtl/icache_line_store.sv | 75 +++++++
 rtl/icache_dm.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared types and address-split helpers for the
// direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    DONE
  } state_e;

  function automatic int byte_w(input int dw);
    return $clog2(dw / 8);
  endfunction

  function automatic int offs_w(input int wl);
    return $clog2(wl);
  endfunction

  function automatic int idx_w(input int ln);
    return $clog2(ln);
  endfunction

  function automatic int tag_w(
    input int aw,
    input int dw,
    input int ln,
    input int wl
  );
    return aw - byte_w(dw) - offs_w(wl) - idx_w(ln);
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// Tag, valid and data arrays of the cache: async read,
// sync word write, sync tag/valid set, one-cycle clear-all.
module icache_line_store
  import icache_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int LINES      = 64,
  parameter int WORDS_LINE = 4,
  parameter int TAG_W      = 22,
  parameter int IDX_W      = 6,
  parameter int CW         = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [CW-1:0]     rd_offs,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [CW-1:0]     wr_offs,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              set_en,
  input  logic [IDX_W-1:0]  set_idx,
  input  logic [TAG_W-1:0]  set_tag,
  input  logic              clr
);

  localparam int AW = $clog2(LINES * WORDS_LINE);

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  valid_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES*WORDS_LINE];
  logic [AW-1:0]     rd_a;
  logic [AW-1:0]     wr_a;

  assign rd_a = AW'(rd_idx) * AW'(WORDS_LINE)
              + AW'(rd_offs);
  assign wr_a = AW'(wr_idx) * AW'(WORDS_LINE)
              + AW'(wr_offs);

  assign rd_data  = data_q[rd_a];
  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];

  // clear-all wins over a same-cycle set
  always_comb begin
    valid_d = valid_q;
    if (clr) begin
      valid_d = '0;
    end else if (set_en) begin
      valid_d[set_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_q[wr_a] <= wr_data;
    end
    if (set_en) begin
      tag_q[set_idx] <= set_tag;
    end
  end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: lookup,
// line refill FSM, flush handling and hit/miss counters.
module icache_dm
  import icache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINES      = 64,
  parameter int WORDS_LINE = 4,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_en,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_instr,
  output logic              cpu_hold,
  input  logic              flush,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_oe_n,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_hold,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int BYTE_W = byte_w(DATA_W);
  localparam int OFFS_W = offs_w(WORDS_LINE);
  localparam int IDX_W  = idx_w(LINES);
  localparam int TAG_W  =
    tag_w(ADDR_W, DATA_W, LINES, WORDS_LINE);
  localparam int CW     = (OFFS_W > 0) ? OFFS_W : 1;
  localparam logic [CW-1:0]    LAST = CW'(WORDS_LINE - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              flushed_q, flushed_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0]  a_idx;
  logic [TAG_W-1:0]  a_tag;
  logic [CW-1:0]     a_offs;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic              hit;
  logic              wr_en;
  logic              set_en;
  logic [ADDR_W-1:0] refill_addr;

  assign a_idx  = cpu_addr[BYTE_W+OFFS_W +: IDX_W];
  assign a_tag  = cpu_addr[ADDR_W-1 -: TAG_W];
  assign a_offs = CW'(cpu_addr >> BYTE_W) & LAST;

  assign refill_addr =
      (ADDR_W'(tag_q) << (ADDR_W - TAG_W))
    | (ADDR_W'(idx_q) << (BYTE_W + OFFS_W))
    | (ADDR_W'(cnt_q) << BYTE_W);

  assign mem_oe_n  = (state_q != REFILL);
  assign mem_addr  = (state_q == REFILL)
                   ? refill_addr : '0;
  assign cpu_instr = rd_data;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

  icache_line_store #(
    .DATA_W     (DATA_W),
    .LINES      (LINES),
    .WORDS_LINE (WORDS_LINE),
    .TAG_W      (TAG_W),
    .IDX_W      (IDX_W),
    .CW         (CW)
  ) u_store (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_idx   (a_idx),
    .rd_offs  (a_offs),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .wr_en    (wr_en),
    .wr_idx   (idx_q),
    .wr_offs  (cnt_q),
    .wr_data  (mem_data),
    .set_en   (set_en),
    .set_idx  (idx_q),
    .set_tag  (tag_q),
    .clr      (flush)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tag_d      = tag_q;
    idx_d      = idx_q;
    flushed_d  = flushed_q | flush;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    hit        = 1'b0;
    cpu_hold   = 1'b0;
    wr_en      = 1'b0;
    set_en     = 1'b0;
    unique case (state_q)
      IDLE: begin
        hit = cpu_en & ~flush & rd_valid
            & (rd_tag == a_tag);
        cpu_hold = cpu_en & ~hit;
        if (hit && hit_cnt_q != CMAX) begin
          hit_cnt_d = hit_cnt_q + 1'b1;
        end
        if (cpu_en && !hit) begin
          tag_d     = a_tag;
          idx_d     = a_idx;
          cnt_d     = '0;
          flushed_d = 1'b0;
          state_d   = REFILL;
          if (miss_cnt_q != CMAX) begin
            miss_cnt_d = miss_cnt_q + 1'b1;
          end
        end
      end
      REFILL: begin
        cpu_hold = 1'b1;
        if (!mem_hold) begin
          wr_en = 1'b1;
          cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        cpu_hold = 1'b1;
        // a flush seen during this refill leaves the line invalid
        set_en   = ~flushed_q & ~flush;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tag_q      <= '0;
      idx_q      <= '0;
      flushed_q  <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tag_q      <= tag_d;
      idx_q      <= idx_d;
      flushed_q  <= flushed_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

endmodule
